// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants for the uart transmit arbiter
// Purpose: byte width and arbiter FSM state encodings used by the arbiter,
//          its bus interface and its testbench.
// Ports:   none (package)
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart-side bus of the transmit arbiter
// Purpose: bundles the producer handshake (req_*) and the uart transmit pins.
// Ports:   req_valid/req_data/req_lock/req_ready - N_REQ byte producers
//          uart_valid/uart_data/tx_busy           - uart transmitter side
//          master = producers + uart (environment), slave = arbiter
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ-1:0]        req_ready;
    logic                    uart_valid;
    logic [BYTE_W-1:0]       uart_data;
    logic                    tx_busy;

    modport master (
        output req_valid, req_data, req_lock, tx_busy,
        input  req_ready, uart_valid, uart_data
    );

    modport slave (
        input  req_valid, req_data, req_lock, tx_busy,
        output req_ready, uart_valid, uart_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational N-way round-robin picker
// Purpose: picks the first asserted request scanning from i_last+1 (mod N).
// Ports:   i_req   - request vector
//          i_last  - index of the previously granted requester
//          o_grant - one-hot grant, o_idx - granted index, o_any - some request won
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // One extra bit so i_last + k (at most 2N-1) never overflows before the wrap.
    logic [IW:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, i_last} + (IW+1)'(k);
            // Explicit compare so non-power-of-two N wraps correctly.
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!o_any && i_req[w_cand[IW-1:0]]) begin
                o_any                   = 1'b1;
                o_idx                   = w_cand[IW-1:0];
                o_grant[w_cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one uart transmitter between N_REQ byte producers
// Purpose: round-robin grant per byte, optional lock for multi-byte messages,
//          one byte in flight at a time with a bounded wait for tx_busy to rise.
// Ports:   clk, rst  - clock, synchronous active-high reset
//          bus       - slave side of uart_tx_arbiter_if (producers + uart pins)
//          owner     - index of the current/last granted requester
//          timeout   - 1-cycle pulse when tx_busy never rose after an issue
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int BUSY_WAIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_arbiter_if.slave         bus,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_WAIT + 1);

    logic [1:0]        r_state;
    logic [IW-1:0]     r_owner;
    logic              r_locked;
    logic [CW-1:0]     r_cnt;
    logic [BYTE_W-1:0] r_data;
    logic              r_timeout;

    logic [N_REQ-1:0]  w_rr_grant;
    logic [IW-1:0]     w_rr_idx;
    logic              w_rr_any;
    logic [N_REQ-1:0]  w_sel_grant;
    logic [IW-1:0]     w_sel_idx;
    logic              w_sel_any;
    logic              w_hold;
    logic              w_accept;
    logic [BYTE_W-1:0] w_sel_data;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_owner),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    always_comb begin
        // A locked owner keeps exclusive eligibility while it either has a byte
        // or still asserts req_lock; once both are low the lock is released and
        // the normal round-robin result is used in the same cycle.
        w_hold      = r_locked && (bus.req_valid[r_owner] || bus.req_lock[r_owner]);
        w_sel_grant = '0;
        w_sel_idx   = r_owner;
        w_sel_any   = 1'b0;
        if (w_hold) begin
            if (bus.req_valid[r_owner]) begin
                w_sel_any            = 1'b1;
                w_sel_grant[r_owner] = 1'b1;
            end
        end else begin
            w_sel_grant = w_rr_grant;
            w_sel_idx   = w_rr_idx;
            w_sel_any   = w_rr_any;
        end
        w_accept = !rst && (r_state == ST_IDLE) && w_sel_any;

        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel_idx == IW'(i)) begin
                w_sel_data = bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Outputs are gated by rst so nothing is emitted during a reset cycle.
    assign bus.req_ready  = w_accept ? w_sel_grant : '0;
    assign bus.uart_valid = !rst && (r_state == ST_ISSUE);
    assign bus.uart_data  = r_data;
    assign owner          = r_owner;
    assign timeout        = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_locked  <= 1'b0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data   <= w_sel_data;
                        r_owner  <= w_sel_idx;
                        r_locked <= bus.req_lock[w_sel_idx];
                        r_state  <= ST_ISSUE;
                    end else if (!w_hold) begin
                        r_locked <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    // A still-high tx_busy from an earlier frame also counts as start.
                    if (bus.tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CW'(BUSY_WAIT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
